// File: rtl/dsadc_pkg.sv
// rtl/dsadc_pkg.sv - shared types and AFE encodings for the dual-slope ADC sequencer
package dsadc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_REF,
      AUTOZERO,
      INTEGRATE,
      DEINT,
      DONE
   } state_e;

   localparam logic [1:0] AFE_SEL_HOLD  = 2'd0;
   localparam logic [1:0] AFE_SEL_AZ    = 2'd1;
   localparam logic [1:0] AFE_SEL_INT   = 2'd2;
   localparam logic [1:0] AFE_SEL_DEINT = 2'd3;

   function automatic logic [1:0] afe_sel_for(state_e s);
      case (s)
         AUTOZERO:  return AFE_SEL_AZ;
         INTEGRATE: return AFE_SEL_INT;
         DEINT:     return AFE_SEL_DEINT;
         default:   return AFE_SEL_HOLD;
      endcase
   endfunction

endpackage

// File: rtl/dsadc_seq_if.sv
// rtl/dsadc_seq_if.sv - control, result and analog-front-end signals of the sequencer
interface dsadc_seq_if #(
   parameter int CNT_W   = 16,
   parameter int RANGE_W = 2
);
   logic               start_i;
   logic [RANGE_W-1:0] range_req_i;
   logic               busy_o;
   logic               done_o;
   logic [CNT_W-1:0]   result_o;
   logic               neg_o;
   logic               ovr_o;
   logic               err_o;
   logic [1:0]         afe_sel_o;
   logic [RANGE_W-1:0] range_sel_o;
   logic               afe_reset_o;
   logic               ref_sign_o;
   logic               comp_i;
   logic               sat_hi_i;
   logic               sat_lo_i;
   logic               ref_ok_i;

   modport slave (
      input  start_i, range_req_i, comp_i, sat_hi_i, sat_lo_i, ref_ok_i,
      output busy_o, done_o, result_o, neg_o, ovr_o, err_o,
             afe_sel_o, range_sel_o, afe_reset_o, ref_sign_o
   );

   modport master (
      output start_i, range_req_i, comp_i, sat_hi_i, sat_lo_i, ref_ok_i,
      input  busy_o, done_o, result_o, neg_o, ovr_o, err_o,
             afe_sel_o, range_sel_o, afe_reset_o, ref_sign_o
   );

endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous status bits
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);
   logic [WIDTH-1:0] meta_q, meta_d;
   logic [WIDTH-1:0] sync_q, sync_d;

   always_comb begin
      meta_d = d_i;
      sync_d = meta_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/dsadc_seq.sv
// rtl/dsadc_seq.sv - autozero / integrate / de-integrate sequencer returning a signed, range-tagged count
module dsadc_seq
   import dsadc_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int RANGE_W     = 2,
   parameter int T_AZ        = 64,
   parameter int T_INT       = 1000,
   parameter int T_DEINT_MAX = 2000,
   parameter int T_REF_TO    = 4096
) (
   input  logic       clk_i,
   input  logic       rst_i,
   dsadc_seq_if.slave bus
);
   localparam logic [CNT_W-1:0] AZ_LAST    = CNT_W'(T_AZ - 1);
   localparam logic [CNT_W-1:0] INT_LAST   = CNT_W'(T_INT - 1);
   localparam logic [CNT_W-1:0] DEINT_LAST = CNT_W'(T_DEINT_MAX - 1);
   localparam logic [CNT_W-1:0] REF_LAST   = CNT_W'(T_REF_TO - 1);

   logic [3:0] status_raw;
   logic [3:0] status_s;
   logic       comp_s;
   logic       sat_s;
   logic       ref_ok_s;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               pol_q, pol_d;
   logic [RANGE_W-1:0] range_q, range_d;
   logic [CNT_W-1:0]   result_q, result_d;
   logic               neg_q, neg_d;
   logic               ovr_q, ovr_d;
   logic               err_q, err_d;

   assign status_raw = {bus.comp_i, bus.sat_hi_i, bus.sat_lo_i, bus.ref_ok_i};

   sync_2ff #(.WIDTH(4)) u_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (status_raw),
      .q_o   (status_s)
   );

   assign comp_s   = status_s[3];
   assign sat_s    = status_s[2] | status_s[1];
   assign ref_ok_s = status_s[0];

   // One counter serves every phase; each exit clears it for the next phase.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pol_d    = pol_q;
      range_d  = range_q;
      result_d = result_q;
      neg_d    = neg_q;
      ovr_d    = ovr_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (bus.start_i) begin
               range_d = bus.range_req_i;
               cnt_d   = '0;
               state_d = WAIT_REF;
            end
         end
         WAIT_REF: begin
            if (ref_ok_s) begin
               cnt_d   = '0;
               state_d = AUTOZERO;
            end else if (cnt_q == REF_LAST) begin
               result_d = '0;
               neg_d    = 1'b0;
               ovr_d    = 1'b0;
               err_d    = 1'b1;
               state_d  = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         AUTOZERO: begin
            if (cnt_q == AZ_LAST) begin
               cnt_d   = '0;
               state_d = INTEGRATE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         INTEGRATE: begin
            if (sat_s) begin
               result_d = '1;
               neg_d    = 1'b0;
               ovr_d    = 1'b1;
               err_d    = 1'b0;
               state_d  = DONE;
            end else if (cnt_q == INT_LAST) begin
               pol_d   = comp_s;
               cnt_d   = '0;
               state_d = DEINT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DEINT: begin
            // A crossing on the limit cycle still counts as an in-range result.
            if (comp_s != pol_q) begin
               result_d = cnt_q;
               neg_d    = pol_q;
               ovr_d    = 1'b0;
               err_d    = 1'b0;
               state_d  = DONE;
            end else if (cnt_q == DEINT_LAST) begin
               result_d = DEINT_LAST;
               neg_d    = pol_q;
               ovr_d    = 1'b1;
               err_d    = 1'b0;
               state_d  = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         pol_q    <= 1'b0;
         range_q  <= '0;
         result_q <= '0;
         neg_q    <= 1'b0;
         ovr_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pol_q    <= pol_d;
         range_q  <= range_d;
         result_q <= result_d;
         neg_q    <= neg_d;
         ovr_q    <= ovr_d;
         err_q    <= err_d;
      end
   end

   assign bus.busy_o      = (state_q != IDLE);
   assign bus.done_o      = (state_q == DONE);
   assign bus.result_o    = result_q;
   assign bus.neg_o       = neg_q;
   assign bus.ovr_o       = ovr_q;
   assign bus.err_o       = err_q;
   assign bus.afe_sel_o   = afe_sel_for(state_q);
   assign bus.range_sel_o = range_q;
   assign bus.afe_reset_o = !((state_q == INTEGRATE) || (state_q == DEINT));
   assign bus.ref_sign_o  = (state_q == DEINT) && !pol_q;

endmodule
